// File: rtl/irq_pending_latch_pkg.sv
// Shared constants for the interrupt request path (pending latch and 8x3 encoder).
package irq_pending_latch_pkg;

  localparam int unsigned IRQ_N          = 8;
  localparam int unsigned IRQ_ID_W       = 3;
  localparam logic [IRQ_N-1:0] IRQ_MASK_RESET = 8'hFF;

endpackage : irq_pending_latch_pkg

// File: rtl/irq_edge_cell.sv
// One request line: edge detector, sticky pending bit and sticky overrun flag.
module irq_edge_cell (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pending,
  output logic overrun
);

  logic req_q;
  logic rise;

  // Rising edge of the (already synchronous) request level.
  always_comb begin
    rise = req & ~req_q;
  end

  // Edge history, pending and overrun state; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= rise | (pending & ~clr);
      overrun <= (rise & pending & ~clr) | (overrun & ~clr);
    end
  end

endmodule : irq_edge_cell

// File: rtl/irq_pending_latch.sv
// Request capture stage ahead of the priority encoder: latches request edges,
// applies the enable mask and clears bits on acknowledge.
module irq_pending_latch
  import irq_pending_latch_pkg::*;
#(
  parameter int unsigned      N          = IRQ_N,
  parameter int unsigned      ID_W       = IRQ_ID_W,
  parameter logic [N-1:0]     MASK_RESET = IRQ_MASK_RESET
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_wdata,
  input  logic            ack,
  input  logic [ID_W-1:0] ack_id,
  output logic [N-1:0]    pend_vec,
  output logic            irq,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  logic [N-1:0] mask;
  logic [N-1:0] clr;

  // Writable enable mask; masking only hides pending bits, it never blocks latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= MASK_RESET;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // One-hot clear from the acknowledge index; indices >= N match nothing.
  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = ack && (ack_id == ID_W'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < int'(N); g++) begin : g_cell
      irq_edge_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .req     (req[g]),
        .clr     (clr[g]),
        .pending (pending[g]),
        .overrun (overrun[g])
      );
    end
  endgenerate

  // Encoder-facing view, purely from registers.
  always_comb begin
    pend_vec = pending & mask;
    irq      = |pend_vec;
  end

endmodule : irq_pending_latch

// File: tb/tb_irq_pending_latch.sv
// Directed, table-driven bench for irq_pending_latch.
module tb_irq_pending_latch;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic [2:0] ack_id;
  logic [7:0] pend_vec;
  logic       irq;
  logic [7:0] pending;
  logic [7:0] overrun;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [7:0] rq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ak;
    logic [2:0] aid;
    logic [7:0] e_pend;
    logic [7:0] e_ov;
    logic [7:0] e_pv;
    logic       e_irq;
  } vec_t;

  vec_t vecs[$];

  irq_pending_latch #(
    .N          (8),
    .ID_W       (3),
    .MASK_RESET (8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .ack_id     (ack_id),
    .pend_vec   (pend_vec),
    .irq        (irq),
    .pending    (pending),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic [7:0] rq,
                              input logic mwe, input logic [7:0] mwd,
                              input logic ak, input logic [2:0] aid,
                              input logic [7:0] e_pend, input logic [7:0] e_ov,
                              input logic [7:0] e_pv, input logic e_irq);
    vec_t v;
    v.rst = rst; v.rq = rq; v.mwe = mwe; v.mwd = mwd; v.ak = ak; v.aid = aid;
    v.e_pend = e_pend; v.e_ov = e_ov; v.e_pv = e_pv; v.e_irq = e_irq;
    vecs.push_back(v);
  endfunction

  task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] rq, input logic mwe,
                       input logic [7:0] mwd, input logic ak, input logic [2:0] aid);
    reset = rst; req = rq; mask_we = mwe; mask_wdata = mwd; ack = ak; ack_id = aid;
  endtask

  // Apply current inputs across one rising edge, then check the registered state.
  task automatic step_check(input int idx, input logic [7:0] e_pend, input logic [7:0] e_ov,
                            input logic [7:0] e_pv, input logic e_irq);
    @(posedge clk);
    #1;
    chk8("pending", idx, pending, e_pend);
    chk8("overrun", idx, overrun, e_ov);
    chk8("pend_vec", idx, pend_vec, e_pv);
    chk1("irq", idx, irq, e_irq);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);

    //   rst  req    mwe   mwd    ack  id    pend   ov     pv     irq
    // reset then idle
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    // level-held req0 for 5 cycles: one event, then ack 0
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    // staggered rises 01 -> 05 -> 85, then acks 7, 2, 0
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 3'd0, 8'h05, 8'h00, 8'h05, 1'b1);
    add(1'b0, 8'h85, 1'b0, 8'h00, 1'b0, 3'd0, 8'h85, 8'h00, 8'h85, 1'b1);
    add(1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd7, 8'h05, 8'h00, 8'h05, 1'b1);
    add(1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd2, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    // mask bit0 off, latch anyway, unmask
    add(1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h01, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    // bit3 overrun, then re-raise concurrent with ack 3
    add(1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00, 8'h08, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00, 8'h08, 1'b1);
    add(1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 8'h08, 8'h08, 8'h08, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h08, 8'h08, 8'h08, 1'b1);
    add(1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3, 8'h08, 8'h00, 8'h08, 1'b1);
    add(1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    // ack of a non-pending bit is harmless
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0);
    // all pending, everything masked, overrun on bit4 despite mask
    add(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 8'h00, 8'hFF, 1'b1);
    add(1'b0, 8'hEF, 1'b1, 8'h00, 1'b0, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 8'h10, 8'h00, 1'b0);
    // mid-operation reset, req held at 02 through release; mask returns to FF
    add(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00, 8'h02, 1'b1);
    add(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00, 8'h02, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rq, vecs[i].mwe, vecs[i].mwd, vecs[i].ak, vecs[i].aid);
      step_check(i, vecs[i].e_pend, vecs[i].e_ov, vecs[i].e_pv, vecs[i].e_irq);
    end

    // Long level hold after ack: must not re-pend.
    drive(1'b0, 8'h02, 1'b0, 8'h00, 1'b1, 3'd1);
    step_check(100, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0);
      step_check(101 + k, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Two lines pending; re-edge on bit4 with its own ack keeps it set without overrun.
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    step_check(120, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h30, 1'b0, 8'h00, 1'b0, 3'd0);
    step_check(121, 8'h30, 8'h00, 8'h30, 1'b1);
    drive(1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0);
    step_check(122, 8'h30, 8'h00, 8'h30, 1'b1);
    drive(1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 3'd4);
    step_check(123, 8'h30, 8'h00, 8'h30, 1'b1);
    drive(1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 3'd5);
    step_check(124, 8'h10, 8'h00, 8'h10, 1'b1);
    drive(1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 3'd6);
    step_check(125, 8'h10, 8'h00, 8'h10, 1'b1);
    drive(1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 3'd4);
    step_check(126, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_irq_pending_latch
